// File: rtl/me_port_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : me_port_sched_pkg
//  Description : Shared definitions for the ME-stage data-memory port
//                scheduler. Holds the FSM state encoding, the default
//                response-timeout constant and the oldest-lane selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package me_port_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ADV   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // Default response-timeout limit in cycles (8-bit range 1..255).
    localparam int unsigned c_TMO_DEFAULT = 255;

    // Lane to serve first among the lanes needing the port. Lane 1 wins only
    // if it is the sole requester, or both request and lane 1 is strictly
    // older (tag 0 against tag 1). Equal tags resolve to lane 0.
    function automatic logic oldest_lane(
        input logic i_need0,
        input logic i_need1,
        input logic i_ord0,
        input logic i_ord1
    );
        return (i_need1 & ~i_need0) | (i_need0 & i_need1 & i_ord0 & ~i_ord1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/me_sched_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : me_sched_wdog
//  Description : Response-timeout counter for me_port_sched. Counts cycles
//                while the scheduler waits for a memory response and flags
//                expiry when the count reaches TMO_CYCLES.
//  Ports       : i_clk      - clock
//                i_rst_n    - synchronous active-low reset
//                i_run      - scheduler is in a response-waiting state
//                i_clr      - scheduler changes state this cycle
//                o_expire   - combinational: limit reached this cycle
//                o_tmo_err  - registered one-cycle timeout pulse
//  Config      : body present only when ME_SCHED_TMO_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef ME_SCHED_TMO_EN
module me_sched_wdog
    import me_port_sched_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = c_TMO_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expire,
    output logic o_tmo_err
);

    // Counter holds 0 in the first waiting cycle, so hitting LIMIT means
    // TMO_CYCLES waiting cycles have elapsed at the end of this one.
    localparam logic [7:0] c_LIMIT = 8'(TMO_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_tmo;

    assign o_expire  = i_run & (r_cnt == c_LIMIT);
    assign o_tmo_err = r_tmo;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
            r_tmo <= 1'b0;
        end else begin
            r_tmo <= o_expire;
            if (i_clr || !i_run) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/me_port_sched.sv
`default_nettype none
// ============================================================================
//  Module      : me_port_sched
//  Description : Arbitrates the single shared data-memory port between the
//                two ME-stage lanes, serving the oldest lane first, and
//                generates the ME->WB advance strobe and upstream stall.
//  Ports       : CLK, RST          - clock, synchronous active-low reset
//                me{0,1}_valid     - lane holds a valid instruction
//                me{0,1}_mem       - lane needs the data-memory port
//                me{0,1}_order     - program-order tag, 0 = older
//                flush             - discard the ME bundle
//                wb_stall          - WB cannot accept
//                dm_gnt, dm_rvalid - memory grant / response valid
//                dm_req, dm_sel    - port request and driving lane
//                memdat{0,1}_WE    - load-data hold register capture
//                ACT, me_stall     - advance strobe, upstream hold
//                tmo_err           - response-timeout pulse
//  Config      : ME_SCHED_TMO_EN enables the response timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module me_port_sched
    import me_port_sched_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = c_TMO_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic me0_valid,
    input  logic me1_valid,
    input  logic me0_mem,
    input  logic me1_mem,
    input  logic me0_order,
    input  logic me1_order,
    input  logic flush,
    input  logic wb_stall,
    input  logic dm_gnt,
    input  logic dm_rvalid,
    output logic dm_req,
    output logic dm_sel,
    output logic memdat0_WE,
    output logic memdat1_WE,
    output logic ACT,
    output logic me_stall,
    output logic tmo_err
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_cur;
    logic       w_cur_nxt;
    logic [1:0] r_served;
    logic [1:0] w_served_nxt;

    logic       w_need0;
    logic       w_need1;
    logic       w_present;
    logic       w_first;
    logic       w_other;
    logic       w_other_pending;
    logic       w_act;
    logic       w_req;
    logic       w_we0;
    logic       w_we1;
    logic       w_expire;

    assign w_need0   = me0_valid & me0_mem;
    assign w_need1   = me1_valid & me1_mem;
    assign w_present = me0_valid | me1_valid;
    assign w_first   = oldest_lane(w_need0, w_need1, me0_order, me1_order);
    assign w_other   = ~r_cur;

    // The other lane still has an access to make in this bundle.
    assign w_other_pending = (w_other ? w_need1 : w_need0) & ~r_served[w_other];

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_served_nxt = r_served;
        w_act        = 1'b0;
        w_req        = 1'b0;
        w_we0        = 1'b0;
        w_we1        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_served_nxt = 2'b00;
                if (!flush) begin
                    if (w_need0 || w_need1) begin
                        w_cur_nxt   = w_first;
                        w_state_nxt = ST_REQ;
                    end else if (w_present && !wb_stall) begin
                        // Non-memory bundle passes straight through.
                        w_act = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                w_req = 1'b1;
                if (flush) begin
                    // A granted request still owes a response: drain it.
                    w_state_nxt = dm_gnt ? ST_DRAIN : ST_IDLE;
                end else if (dm_gnt) begin
                    w_state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (dm_rvalid) begin
                    if (flush) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_we0 = ~r_cur;
                        w_we1 = r_cur;
                        w_served_nxt[r_cur] = 1'b1;
                        if (w_other_pending) begin
                            w_cur_nxt   = w_other;
                            w_state_nxt = ST_REQ;
                        end else begin
                            w_state_nxt = ST_ADV;
                        end
                    end
                end else if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end

            ST_ADV: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (!wb_stall) begin
                    w_act       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                if (dm_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A timed-out wait abandons the transaction.
        if (w_expire) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= ST_IDLE;
            r_cur    <= 1'b0;
            r_served <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_cur    <= w_cur_nxt;
            r_served <= w_served_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Optional response timeout
    // ------------------------------------------------------------------
`ifdef ME_SCHED_TMO_EN
    logic w_run;
    logic w_clr;
    logic w_tmo;

    assign w_run = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
    // Any state change restarts the count on entry to the next state.
    assign w_clr = (w_state_nxt != r_state);

    me_sched_wdog #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_wdog (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_run     (w_run),
        .i_clr     (w_clr),
        .o_expire  (w_expire),
        .o_tmo_err (w_tmo)
    );

    assign tmo_err = RST & w_tmo;
`else
    logic w_unused_tmo;

    assign w_unused_tmo = |8'(TMO_CYCLES);
    assign w_expire     = 1'b0;
    assign tmo_err      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs; all forced low while reset is held.
    // ------------------------------------------------------------------
    assign ACT        = RST & w_act;
    assign dm_req     = RST & w_req;
    assign dm_sel     = RST & w_req & r_cur;
    assign memdat0_WE = RST & w_we0;
    assign memdat1_WE = RST & w_we1;
    assign me_stall   = RST & ((w_present & ~w_act) | (r_state == ST_DRAIN));

endmodule
`default_nettype wire

// File: tb/tb_me_port_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_me_port_sched
//  Description : Self-checking bench for me_port_sched. Directed scenarios
//                plus randomized bundles checked against a transaction-level
//                model of the service order and handshake timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_me_port_sched;

`ifdef ME_SCHED_TMO_EN
    localparam int unsigned TB_TMO = 4;
`else
    localparam int unsigned TB_TMO = 255;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic me0_valid = 1'b0, me1_valid = 1'b0;
    logic me0_mem = 1'b0, me1_mem = 1'b0;
    logic me0_order = 1'b0, me1_order = 1'b0;
    logic flush = 1'b0, wb_stall = 1'b0, dm_gnt = 1'b0, dm_rvalid = 1'b0;
    logic dm_req, dm_sel, memdat0_WE, memdat1_WE, ACT, me_stall, tmo_err;

    int n_chk = 0;
    int n_err = 0;

    // {ACT, me_stall, dm_req, dm_sel, memdat1_WE, memdat0_WE, tmo_err}
    logic [6:0] w_obs;
    assign w_obs = {ACT, me_stall, dm_req, dm_sel, memdat1_WE, memdat0_WE, tmo_err};

    me_port_sched #(
        .TMO_CYCLES (TB_TMO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .me0_valid  (me0_valid),
        .me1_valid  (me1_valid),
        .me0_mem    (me0_mem),
        .me1_mem    (me1_mem),
        .me0_order  (me0_order),
        .me1_order  (me1_order),
        .flush      (flush),
        .wb_stall   (wb_stall),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_req     (dm_req),
        .dm_sel     (dm_sel),
        .memdat0_WE (memdat0_WE),
        .memdat1_WE (memdat1_WE),
        .ACT        (ACT),
        .me_stall   (me_stall),
        .tmo_err    (tmo_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] pk(input logic act, input logic stall, input logic req,
                                      input logic sel, input logic we1, input logic we0,
                                      input logic tmo);
        return {act, stall, req, sel, we1, we0, tmo};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic set_in(input logic v0, input logic v1, input logic m0, input logic m1,
                          input logic o0, input logic o1, input logic fl, input logic ws,
                          input logic gnt, input logic rv);
        me0_valid = v0; me1_valid = v1; me0_mem = m0; me1_mem = m1;
        me0_order = o0; me1_order = o1; flush = fl; wb_stall = ws;
        dm_gnt = gnt; dm_rvalid = rv;
    endtask

    // Rows: {RST, v0, m0, flush, gnt, rvalid, expected outputs}; lane 1 idle.
    task automatic test_reset();
        logic [12:0] t [9];
        t = '{13'b0_11000_0000000, 13'b0_11000_0000000,
              13'b1_11000_0100000, 13'b1_11010_0110000, 13'b1_11000_0100000,
              13'b0_11000_0000000, 13'b1_00001_0000000,
              13'b1_10000_1000000, 13'b1_00000_0000000};
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            RST = t[i][12];
            set_in(t[i][11], 1'b0, t[i][10], 1'b0, 1'b0, 1'b0, t[i][9], 1'b0, t[i][8], t[i][7]);
            #1;
            n_chk++;
            if (w_obs !== t[i][6:0]) begin
                n_err++;
                $display("FAIL reset[%0d]: got %b expected %b", i, w_obs, t[i][6:0]);
            end
        end
    endtask

    // Transaction-level model: the lanes needing memory are served oldest
    // first; each takes one REQ cycle per grant delay plus the grant cycle,
    // then one WAIT cycle per response delay plus the response cycle.
    task automatic test_bundle(input string tag, input logic v0, input logic v1,
                               input logic m0, input logic m1, input logic o0, input logic o1,
                               input int gd0, input int gd1, input int rd0, input int rd1,
                               input int ws);
        int         lanes[$];
        int         ln, gd, rd;
        logic [6:0] e;
        if ((v0 & m0) && (v1 & m1)) begin
            if (o1 < o0) begin lanes.push_back(1); lanes.push_back(0); end
            else         begin lanes.push_back(0); lanes.push_back(1); end
        end else if (v0 & m0) lanes.push_back(0);
        else if (v1 & m1)     lanes.push_back(1);

        if (lanes.size() == 0) begin
            for (int k = 0; k <= ws; k++) begin
                @(negedge CLK);
                set_in(v0, v1, m0, m1, o0, o1, 1'b0, k < ws, 1'b0, rb());
                #1;
                e = (v0 | v1) ? pk(k == ws, k < ws, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0) : 7'd0;
                n_chk++;
                if (w_obs !== e) begin
                    n_err++;
                    $display("FAIL %s nomem k=%0d: got %b expected %b", tag, k, w_obs, e);
                end
            end
        end else begin
            @(negedge CLK);
            set_in(v0, v1, m0, m1, o0, o1, 1'b0, rb(), 1'b0, rb());
            #1;
            e = pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_chk++;
            if (w_obs !== e) begin
                n_err++;
                $display("FAIL %s idle: got %b expected %b", tag, w_obs, e);
            end
            for (int i = 0; i < lanes.size(); i++) begin
                ln = lanes[i];
                gd = (i == 0) ? gd0 : gd1;
                rd = (i == 0) ? rd0 : rd1;
                for (int k = 0; k <= gd; k++) begin
                    @(negedge CLK);
                    set_in(v0, v1, m0, m1, o0, o1, 1'b0, rb(), k == gd, rb());
                    #1;
                    e = pk(1'b0, 1'b1, 1'b1, ln[0], 1'b0, 1'b0, 1'b0);
                    n_chk++;
                    if (w_obs !== e) begin
                        n_err++;
                        $display("FAIL %s req lane%0d k=%0d: got %b expected %b", tag, ln, k, w_obs, e);
                    end
                end
                for (int k = 0; k <= rd; k++) begin
                    @(negedge CLK);
                    set_in(v0, v1, m0, m1, o0, o1, 1'b0, rb(), 1'b0, k == rd);
                    #1;
                    e = pk(1'b0, 1'b1, 1'b0, 1'b0, (ln == 1) && (k == rd), (ln == 0) && (k == rd), 1'b0);
                    n_chk++;
                    if (w_obs !== e) begin
                        n_err++;
                        $display("FAIL %s wait lane%0d k=%0d: got %b expected %b", tag, ln, k, w_obs, e);
                    end
                end
            end
            for (int k = 0; k <= ws; k++) begin
                @(negedge CLK);
                set_in(v0, v1, m0, m1, o0, o1, 1'b0, k < ws, 1'b0, rb());
                #1;
                e = pk(k == ws, k < ws, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                n_chk++;
                if (w_obs !== e) begin
                    n_err++;
                    $display("FAIL %s adv k=%0d: got %b expected %b", tag, k, w_obs, e);
                end
            end
        end
        @(negedge CLK);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_chk++;
        if (w_obs !== 7'd0) begin
            n_err++;
            $display("FAIL %s gap: got %b expected 0000000", tag, w_obs);
        end
    endtask

    task automatic test_directed_bundles();
        test_bundle("no_mem",    1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        test_bundle("order10",   1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0);
        test_bundle("order_eq0", 1, 1, 1, 1, 0, 0, 0, 1, 0, 2, 1);
        test_bundle("order_eq1", 1, 1, 1, 1, 1, 1, 2, 0, 1, 0, 0);
        test_bundle("gnt_delay", 1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0);
        test_bundle("adv_stall", 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 5);
        test_bundle("nomem_ws",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    endtask

    // Rows: {v0, m0, flush, gnt, rvalid, expected outputs}; lane 1 idle.
    task automatic test_flush();
        logic [11:0] t [32];
        t = '{12'b11000_0100000, 12'b11010_0110000, 12'b11100_0100000, 12'b00000_0100000,
              12'b00001_0100000, 12'b00000_0000000, 12'b00001_0000000,
              12'b11000_0100000, 12'b11100_0110000, 12'b00000_0000000,
              12'b11000_0100000, 12'b11110_0110000, 12'b00000_0100000, 12'b00001_0100000,
              12'b00000_0000000,
              12'b11000_0100000, 12'b11010_0110000, 12'b11101_0100000, 12'b00000_0000000,
              12'b11000_0100000, 12'b11010_0110000, 12'b11001_0100010, 12'b11100_0100000,
              12'b00000_0000000,
              12'b10100_0100000, 12'b00000_0000000,
              12'b11000_0100000, 12'b11001_0110000, 12'b11010_0110000, 12'b11001_0100010,
              12'b11000_1000000, 12'b00000_0000000};
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            set_in(t[i][11], 1'b0, t[i][10], 1'b0, 1'b0, 1'b0, t[i][9], 1'b0, t[i][8], t[i][7]);
            #1;
            n_chk++;
            if (w_obs !== t[i][6:0]) begin
                n_err++;
                $display("FAIL flush[%0d]: got %b expected %b", i, w_obs, t[i][6:0]);
            end
        end
    endtask

`ifdef ME_SCHED_TMO_EN
    task automatic test_timeout();
        logic [11:0] t [16];
        t = '{12'b11000_0100000, 12'b11010_0110000,
              12'b11000_0100000, 12'b11000_0100000, 12'b11000_0100000, 12'b11000_0100000,
              12'b00000_0000001, 12'b00000_0000000,
              12'b11000_0100000, 12'b11110_0110000,
              12'b00000_0100000, 12'b00000_0100000, 12'b00000_0100000, 12'b00000_0100000,
              12'b00000_0000001, 12'b00000_0000000};
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            set_in(t[i][11], 1'b0, t[i][10], 1'b0, 1'b0, 1'b0, t[i][9], 1'b0, t[i][8], t[i][7]);
            #1;
            n_chk++;
            if (w_obs !== t[i][6:0]) begin
                n_err++;
                $display("FAIL timeout[%0d]: got %b expected %b", i, w_obs, t[i][6:0]);
            end
        end
    endtask
`else
    task automatic test_long_wait();
        logic [4:0] s;
        logic [6:0] e;
        for (int i = 0; i < 25; i++) begin
            if (i == 0)       begin s = 5'b11000; e = 7'b0100000; end
            else if (i == 1)  begin s = 5'b11010; e = 7'b0110000; end
            else if (i < 22)  begin s = 5'b11000; e = 7'b0100000; end
            else if (i == 22) begin s = 5'b11001; e = 7'b0100010; end
            else if (i == 23) begin s = 5'b11000; e = 7'b1000000; end
            else              begin s = 5'b00000; e = 7'b0000000; end
            @(negedge CLK);
            set_in(s[4], 1'b0, s[3], 1'b0, 1'b0, 1'b0, s[2], 1'b0, s[1], s[0]);
            #1;
            n_chk++;
            if (w_obs !== e) begin
                n_err++;
                $display("FAIL long_wait[%0d]: got %b expected %b", i, w_obs, e);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            test_bundle("random", rb(), rb(), rb(), rb(), rb(), rb(),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                        int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_directed_bundles();
        test_flush();
`ifdef ME_SCHED_TMO_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/me_port_sched.md
ME_PORT_SCHED -- requirements
Module: me_port_sched

Interface
REQ-001 Parameter TMO_CYCLES, default 255, SHALL set the response-timeout limit in cycles (8-bit, 1..255).
REQ-002 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 RST  in  1  reset, synchronous, active-low.
REQ-004 me0_valid / me1_valid  in  1 each  lane holds a valid instruction in the ME stage.
REQ-005 me0_mem / me1_mem  in  1 each  lane needs the shared data-memory port (load/store).
REQ-006 me0_order / me1_order  in  1 each  program-order tag; 0 = older.
REQ-007 flush  in  1  discard the ME bundle.
REQ-008 wb_stall  in  1  WB stage cannot accept.
REQ-009 dm_gnt  in  1  memory accepted the request; dm_rvalid  in  1  response data valid.
REQ-010 dm_req  out  1  request on shared port; dm_sel  out  1  lane driving the port.
REQ-011 memdat0_WE / memdat1_WE  out  1 each  capture enable for the lane's load-data hold register.
REQ-012 ACT  out  1  advance strobe for both ME->WB output units; me_stall  out  1  hold upstream stages.
REQ-013 tmo_err  out  1  one-cycle timeout pulse (only with ME_SCHED_TMO_EN).

Function
REQ-014 FSM states SHALL be IDLE, REQ, WAIT, ADV, DRAIN.
REQ-015 need[i] = me_i_valid & me_i_mem; a bundle is present when either lane is valid.
REQ-016 Service order SHALL be oldest-first by order tag; equal tags SHALL serve lane 0 first.
REQ-017 IDLE, bundle present, no need, !wb_stall, !flush: ACT=1 combinationally, same cycle, stay IDLE.
REQ-018 IDLE, any need, !flush: ACT=0, latch cur = oldest needing lane, go REQ next cycle.
REQ-019 REQ: dm_req=1, dm_sel=cur; dm_gnt -> WAIT; otherwise hold REQ with dm_req held high.
REQ-020 WAIT: on dm_rvalid, memdat{cur}_WE=1 for exactly that cycle; if the other lane needs and is not served -> REQ with cur=other; else -> ADV.
REQ-021 ADV: ACT=1 when !wb_stall, then -> IDLE; with wb_stall hold ADV, ACT=0.
REQ-022 At most one request outstanding; each lane served at most once per bundle.
REQ-023 me_stall = bundle present & !ACT, and SHALL be 1 in DRAIN regardless.
REQ-024 flush in IDLE, ADV, or REQ without dm_gnt: ACT=0, next state IDLE, no WE.
REQ-025 flush in REQ with dm_gnt, or in WAIT without dm_rvalid: -> DRAIN; flush in WAIT with dm_rvalid: WE suppressed, -> IDLE.
REQ-026 DRAIN: dm_req=0, no WE; on dm_rvalid -> IDLE.
REQ-027 dm_rvalid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-028 RST low at a clock edge SHALL force IDLE, cur=0, served flags and timeout counter 0, all outputs 0, including mid-transaction; a pending response after reset SHALL be ignored.

Configuration
REQ-029 Macro ME_SCHED_TMO_EN defined: an 8-bit counter runs in WAIT/DRAIN, clears on state entry; reaching TMO_CYCLES pulses tmo_err for one cycle and forces IDLE.
REQ-030 Without ME_SCHED_TMO_EN: no counter, tmo_err tied 0, WAIT/DRAIN wait indefinitely.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding and the default timeout constant.
REQ-032 Timeout counter SHALL be sub-module me_sched_wdog, instantiated only under ME_SCHED_TMO_EN.

Verification
REQ-033 Both valid, no mem, wb_stall=0 -> ACT=1 same cycle, me_stall=0, dm_req=0.
REQ-034 Both mem, me0_order=1, me1_order=0, gnt immediate, rvalid 2 cycles later each -> dm_sel=1 first, memdat1_WE then memdat0_WE, ACT in ADV.
REQ-035 Lane0 mem, dm_gnt low 3 cycles -> dm_req high 4 cycles, me_stall=1 throughout.
REQ-036 flush in WAIT, rvalid 2 cycles later -> DRAIN, no WE, IDLE after rvalid.
REQ-037 ADV with wb_stall=1 for 5 cycles -> ACT=0 for 5 cycles, ACT=1 on release.
REQ-038 ME_SCHED_TMO_EN, TMO_CYCLES=4, no rvalid -> tmo_err one-cycle pulse 4 cycles after WAIT entry, state IDLE.
